// File: rtl/reg_writeback_queue_pkg.sv
// Shared CPU constants and the writeback entry type.
// Provides DATA_W/ADDR_W/NUM_REGS, the queue sizing defaults, the
// zero-register constant and wb_entry_t {addr, data}.
package cpu_pkg;
    localparam int DATA_W   = 24;
    localparam int ADDR_W   = 3;
    localparam int NUM_REGS = 8;
    localparam int DEPTH    = 4;
    localparam int CNT_W    = 3;

    localparam logic [ADDR_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_entry_t;
endpackage

// File: rtl/reg_writeback_queue_if.sv
// Bus bundle for reg_writeback_queue.
// master: producers (ALU, MEM), flush source, drain enable, decode forward
//         selector; receives readies, register-file write port, forward
//         result, pending vector and queue status.
// slave : the writeback queue itself.
interface reg_writeback_queue_if;
    import cpu_pkg::*;

    logic                flush;
    logic                alu_valid;
    logic [ADDR_W-1:0]   alu_addr;
    logic [DATA_W-1:0]   alu_data;
    logic                alu_ready;
    logic                mem_valid;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_data;
    logic                mem_ready;
    logic                drain_en;
    logic                RegWrite;
    logic [ADDR_W-1:0]   write_address;
    logic [DATA_W-1:0]   write_data;
    logic [ADDR_W-1:0]   fwd_sel;
    logic                fwd_hit;
    logic [DATA_W-1:0]   fwd_data;
    logic [NUM_REGS-1:0] pending;
    logic                full;
    logic                empty;

    modport master (
        output flush, alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data,
               drain_en, fwd_sel,
        input  alu_ready, mem_ready, RegWrite, write_address, write_data,
               fwd_hit, fwd_data, pending, full, empty
    );

    modport slave (
        input  flush, alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data,
               drain_en, fwd_sel,
        output alu_ready, mem_ready, RegWrite, write_address, write_data,
               fwd_hit, fwd_data, pending, full, empty
    );
endinterface

// File: rtl/reg_writeback_queue_fifo.sv
// wb_fifo: in-order storage for pending register writes.
// Ports: clk, rst (sync, active-high), clr (flush), push/push_entry,
//        pop, head (0 when empty), full/empty, fwd_sel -> fwd_hit/fwd_data
//        (youngest valid entry targeting fwd_sel).
module wb_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = cpu_pkg::DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              push,
    input  wb_entry_t         push_entry,
    input  logic              pop,
    input  logic [ADDR_W-1:0] fwd_sel,
    output wb_entry_t         head,
    output logic              full,
    output logic              empty,
    output logic              fwd_hit,
    output logic [DATA_W-1:0] fwd_data
);
    localparam int PTR_W = $clog2(DEPTH);

    wb_entry_t        mem [DEPTH];
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;
    logic [PTR_W:0]   count;
    logic [PTR_W-1:0] slot;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst && !clr) mem[wr_ptr[PTR_W-1:0]] <= push_entry;
    end

    // Extra wrap bit distinguishes full from empty when indices coincide.
    assign count = wr_ptr - rd_ptr;
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign head  = empty ? '0 : mem[rd_ptr[PTR_W-1:0]];

    // Walk oldest to youngest so the last match (youngest) wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        slot     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot = rd_ptr[PTR_W-1:0] + PTR_W'(i);
            if (((PTR_W+1)'(i) < count) && (fwd_sel != REG_ZERO) &&
                (mem[slot].addr == fwd_sel)) begin
                fwd_hit  = 1'b1;
                fwd_data = mem[slot].data;
            end
        end
    end
endmodule

// File: rtl/reg_writeback_queue.sv
// reg_writeback_queue: writer side of the 8x24-bit register file.
// Ports: clk, rst (sync, active-high), bus (slave modport) carrying
//        flush, ALU/MEM valid-ready producers, drain_en, the register-file
//        write port (RegWrite/write_address/write_data), forward lookup
//        (fwd_sel/fwd_hit/fwd_data), pending vector and full/empty.
// Holds producer arbitration (mem over alu), R0 filtering and the
// per-register pending counters; storage lives in wb_fifo.
module reg_writeback_queue
    import cpu_pkg::*;
#(
    parameter int DEPTH = cpu_pkg::DEPTH,
    parameter int CNT_W = cpu_pkg::CNT_W
) (
    input logic                  clk,
    input logic                  rst,
    reg_writeback_queue_if.slave bus
);
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_hit;
    logic [DATA_W-1:0] fifo_fwd;
    wb_entry_t         head;
    wb_entry_t         push_entry;
    logic              accept_mem;
    logic              accept_alu;
    logic              push;
    logic              pop;

    logic [CNT_W-1:0]    cnt [NUM_REGS];
    logic [NUM_REGS-1:0] inc_vec;
    logic [NUM_REGS-1:0] dec_vec;
    logic [NUM_REGS-1:0] pending_vec;

    // Ready is based on registered full: a pop in the same cycle does not
    // make room for an enqueue until the next cycle.
    assign bus.mem_ready = !rst && !bus.flush && !fifo_full;
    assign bus.alu_ready = !rst && !bus.flush && !fifo_full && !bus.mem_valid;
    assign accept_mem    = bus.mem_valid && bus.mem_ready;
    assign accept_alu    = bus.alu_valid && bus.alu_ready;

    always_comb begin
        push_entry = '0;
        if (accept_mem) begin
            push_entry.addr = bus.mem_addr;
            push_entry.data = bus.mem_data;
        end else if (accept_alu) begin
            push_entry.addr = bus.alu_addr;
            push_entry.data = bus.alu_data;
        end
    end

    // Writes to R0 are accepted but dropped here.
    assign push = (accept_mem || accept_alu) && (push_entry.addr != REG_ZERO);
    assign pop  = !rst && !bus.flush && !fifo_empty && bus.drain_en;

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .clr        (bus.flush),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .fwd_sel    (bus.fwd_sel),
        .head       (head),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .fwd_hit    (fifo_hit),
        .fwd_data   (fifo_fwd)
    );

    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        if (push) inc_vec[push_entry.addr] = 1'b1;
        if (pop)  dec_vec[head.addr]       = 1'b1;
    end

    always_ff @(posedge clk) begin
        for (int r = 0; r < NUM_REGS; r++) begin
            if (rst || bus.flush) begin
                cnt[r] <= '0;
            end else begin
                case ({inc_vec[r], dec_vec[r]})
                    2'b10:   cnt[r] <= cnt[r] + 1'b1;
                    2'b01:   cnt[r] <= cnt[r] - 1'b1;
                    default: cnt[r] <= cnt[r];
                endcase
            end
        end
    end

    always_comb begin
        pending_vec = '0;
        for (int r = 0; r < NUM_REGS; r++) pending_vec[r] = (cnt[r] != '0);
    end

    // Outputs are forced to reset values while rst is high, including the
    // first reset cycle before the state registers have been cleared.
    assign bus.RegWrite      = pop;
    assign bus.write_address = rst ? '0 : head.addr;
    assign bus.write_data    = rst ? '0 : head.data;
    assign bus.fwd_hit       = !rst && fifo_hit;
    assign bus.fwd_data      = rst ? '0 : fifo_fwd;
    assign bus.pending       = rst ? '0 : pending_vec;
    assign bus.full          = !rst && fifo_full;
    assign bus.empty         = rst || fifo_empty;
endmodule
